// File: rtl/decade_cascade_display_pkg.sv
// Shared constants for the decade cascade display.
//  - DIG_W / bcd_t : width and type of one BCD digit
//  - SEG_LUT       : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//  - SEG_BLANK     : all segments off
//  - SEG_DASH      : only segment g lit ("-")
package decade_cascade_display_pkg;

  localparam int DIG_W = 4;
  typedef logic [DIG_W-1:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry [d] is the pattern for digit d; listed from 9 down to 0.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/decade_cascade_display_bcd_to_7seg.sv
// BCD to active-low 7-segment decoder.
//  bcd_i : 4-bit BCD digit
//  seg_o : {g,f,e,d,c,b,a}, active-low; any code above 9 decodes to blank
module bcd_to_7seg
  import decade_cascade_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_LUT[bcd_i];
  end

endmodule

// File: rtl/decade_cascade_display.sv
// Extends an external units decade counter into a 4-digit BCD count (0000..9999)
// and drives a multiplexed active-low 4-digit 7-segment display with it.
//  clk       : system clock, rising edge
//  rst       : synchronous reset, active-low
//  digit_in  : units BCD digit from the decade counter
//  count_bcd : {thousands, hundreds, tens, units}, registered
//  carry_out : one-cycle pulse on 9999 -> 0000
//  err       : sticky, set when digit_in > 9 is seen
//  an        : active-low digit enables, an[0] = units
//  seg       : active-low segments {g,f,e,d,c,b,a}
module decade_cascade_display
  import decade_cascade_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  output logic [15:0] count_bcd,
  output logic        carry_out,
  output logic        err,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  bcd_t [3:0]    dig_q, dig_d;
  bcd_t          prev_q;
  logic          prev_vld_q;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          in_ok, wrap, c, blank;
  bcd_t          dec_in;
  logic [6:0]    dec_seg;

  // Count and scan next state.
  always_comb begin
    in_ok = (digit_in <= 4'd9);
    // A wrap needs a valid 9 followed by a valid 0; the first sample after
    // reset has no predecessor, so a reset-induced 9->0 never carries.
    wrap  = prev_vld_q && (prev_q == 4'd9) && (digit_in == 4'd0);

    dig_d = dig_q;
    if (in_ok) dig_d[0] = digit_in;

    // Ripple the wrap through tens, hundreds, thousands.
    c = wrap;
    for (int k = 1; k < 4; k++) begin
      if (c) begin
        if (dig_q[k] == 4'd9) begin
          dig_d[k] = '0;
        end else begin
          dig_d[k] = dig_q[k] + 4'd1;
          c        = 1'b0;
        end
      end
    end
    carry_d = c;

    err_d = err_q | ~in_ok;

    if (cnt_q == TERM) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
  end

  // Display selection works on next-state values so an/seg always match
  // the registered scan index and count in the same cycle.
  always_comb begin
    case (idx_d)
      2'd1:    blank = (dig_d[3:1] == '0);
      2'd2:    blank = (dig_d[3:2] == '0);
      2'd3:    blank = (dig_d[3] == '0);
      default: blank = 1'b0;
    endcase
    blank  = blank && LZ_BLANK;
    // A non-BCD code makes the decoder output blank.
    dec_in = blank ? 4'hF : dig_d[idx_d];
    an_d   = ~(4'b0001 << idx_d);
  end

  bcd_to_7seg u_dec (
    .bcd_i (dec_in),
    .seg_o (dec_seg)
  );

  assign seg_d = ((idx_d == 2'd0) && err_d) ? SEG_DASH : dec_seg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dig_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_LUT[0];
    end else begin
      dig_q      <= dig_d;
      prev_q     <= digit_in;
      prev_vld_q <= 1'b1;
      carry_q    <= carry_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign count_bcd = dig_q;
  assign carry_out = carry_q;
  assign err       = err_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule
